// File: rtl/ring_decoder_if.sv
// Ring link bundle between the one-hot ring source and its decoder.
// The master side drives the sampled ring word; the slave side reports decode and lock status.
interface ring_decoder_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             ring_vld;
    logic [IW-1:0]    idx;
    logic             idx_vld;
    logic             onehot_err;
    logic             seq_err;
    logic             wrap;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output ring_in,
        output ring_vld,
        input  idx,
        input  idx_vld,
        input  onehot_err,
        input  seq_err,
        input  wrap,
        input  locked,
        input  err_count
    );

    modport slave (
        input  ring_in,
        input  ring_vld,
        output idx,
        output idx_vld,
        output onehot_err,
        output seq_err,
        output wrap,
        output locked,
        output err_count
    );
endinterface

// File: rtl/ring_decoder.sv
// Receive side of the one-hot ring link: decodes each sample to an index and
// tracks rotate-left succession with a HUNT/LOCKED synchroniser.
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    ring_decoder_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    localparam logic [IW-1:0] LAST     = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_TGT = MW'(LOSS_CNT);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    ref_q;
    logic [IW-1:0]    ref_d;
    logic             ref_vld_q;
    logic             ref_vld_d;
    logic [GW-1:0]    good_q;
    logic [GW-1:0]    good_d;
    logic [IW-1:0]    exp_q;
    logic [IW-1:0]    exp_d;
    logic [MW-1:0]    miss_q;
    logic [MW-1:0]    miss_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic             idx_vld_q;
    logic             idx_vld_d;
    logic             oh_err_q;
    logic             oh_err_d;
    logic             seq_err_q;
    logic             seq_err_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;

    logic [CW-1:0]    ones;
    logic [IW-1:0]    pos;
    logic             legal;

    function automatic logic [IW-1:0] succ(input logic [IW-1:0] i);
        return (i == LAST) ? '0 : i + IW'(1);
    endfunction

    // Population count and bit position of the sampled word.
    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) begin
                ones = ones + CW'(1);
                pos  = IW'(i);
            end
        end
    end

    assign legal = (ones == CW'(1));

    // Synchroniser next state, decode outputs and error accounting.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        good_d    = good_q;
        exp_d     = exp_q;
        miss_d    = miss_q;
        idx_d     = idx_q;
        err_d     = err_q;
        idx_vld_d = 1'b0;
        oh_err_d  = 1'b0;
        seq_err_d = 1'b0;
        wrap_d    = 1'b0;

        if (bus.ring_vld) begin
            idx_vld_d = legal;
            oh_err_d  = !legal;
            if (legal) begin
                idx_d = pos;
            end

            unique case (state_q)
                HUNT: begin
                    if (!legal) begin
                        ref_vld_d = 1'b0;
                        good_d    = '0;
                    end else if (ref_vld_q && pos == succ(ref_q)) begin
                        ref_d  = pos;
                        wrap_d = (pos == '0);
                        if (good_q + GW'(1) == GOOD_TGT) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            miss_d  = '0;
                            exp_d   = succ(pos);
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        // Any legal non-successor restarts the hunt from here.
                        ref_d     = pos;
                        ref_vld_d = 1'b1;
                        good_d    = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expectation advances on every sample.
                    exp_d = succ(exp_q);
                    if (legal && pos == exp_q) begin
                        miss_d = '0;
                        wrap_d = (pos == '0);
                    end else begin
                        seq_err_d = legal;
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (miss_q + MW'(1) == MISS_TGT) begin
                            state_d   = HUNT;
                            miss_d    = '0;
                            good_d    = '0;
                            ref_vld_d = legal;
                            ref_d     = legal ? pos : ref_q;
                        end else begin
                            miss_d = miss_q + MW'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            good_q    <= '0;
            exp_q     <= '0;
            miss_q    <= '0;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
            oh_err_q  <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            good_q    <= good_d;
            exp_q     <= exp_d;
            miss_q    <= miss_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_vld_d;
            oh_err_q  <= oh_err_d;
            seq_err_q <= seq_err_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign bus.idx        = idx_q;
    assign bus.idx_vld    = idx_vld_q;
    assign bus.onehot_err = oh_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.wrap       = wrap_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.err_count  = err_q;
endmodule
